// File: rtl/linked_list_fifo_mq.sv
// linked_list_fifo_mq
//   FIFOS logical queues share one DEPTH-entry data RAM. Each queue is a
//   singly linked list (link RAM) and unused entries sit on a free list.
//   Push takes the free-list head, pop and flush return entries to the
//   free-list tail. Flush splices a whole queue onto the free list in one cycle.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   push/push_fifo/d    enqueue d onto queue push_fifo
//   pop/pop_fifo        dequeue head of pop_fifo; q/q_valid the next cycle
//   flush/flush_fifo    discard queue flush_fifo (wins over push/pop)
//   empty[i]            queue i holds no entries
//   full, almost_full   free list empty / free_count <= AF_SLACK
//   free_count          free entries, 0..DEPTH
//   count               per-queue occupancy, queue i at [i*CW +: CW]
//
// Optional build macro LINKED_LIST_FIFO_MQ_ERROR_CHECK_EN adds a sticky
// `error` output: illegal push/pop or a broken accounting/link invariant.
module linked_list_fifo_mq #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int FIFOS    = 8,
    parameter int AF_SLACK = 4,
    localparam int QW = (FIFOS > 1) ? $clog2(FIFOS) : 1,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [QW-1:0]         push_fifo,
    input  logic                  pop,
    input  logic [QW-1:0]         pop_fifo,
    input  logic                  flush,
    input  logic [QW-1:0]         flush_fifo,
    input  logic [WIDTH-1:0]      d,
`ifdef LINKED_LIST_FIFO_MQ_ERROR_CHECK_EN
    output logic                  error,
`endif
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic [FIFOS-1:0]      empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [CW-1:0]         free_count,
    output logic [FIFOS*CW-1:0]   count
);

    logic [WIDTH-1:0]         mem  [DEPTH];
    logic [PW-1:0]            link [DEPTH];
    logic [PW-1:0]            head [FIFOS];
    logic [PW-1:0]            tail [FIFOS];
    logic [FIFOS-1:0][CW-1:0] cnt;
    logic [PW-1:0]            free_head, free_tail;
    logic                     push_ok, pop_ok, flush_ok, same_one;
    logic [PW-1:0]            e, h;
    logic [CW-1:0]            free_n;

    assign push_ok  = push && !full && !flush;
    assign pop_ok   = pop && !empty[pop_fifo] && !flush;
    assign flush_ok = flush && !empty[flush_fifo];
    assign e        = free_head;
    assign h        = head[pop_fifo];
    // Push and pop on the same single-entry queue: the pushed entry becomes
    // the head directly, since the old head's link is not valid yet.
    assign same_one = push_ok && pop_ok && (push_fifo == pop_fifo) && (cnt[pop_fifo] == CW'(1));
    assign count    = cnt;

    always_comb begin
        for (int i = 0; i < FIFOS; i++) empty[i] = (cnt[i] == '0);
    end

    always_comb begin
        free_n = free_count;
        if (flush_ok) free_n = free_count + cnt[flush_fifo];
        else          free_n = free_count - CW'(push_ok) + CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[e] <= d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) link[i] <= PW'(i + 1);
            for (int i = 0; i < FIFOS; i++) begin
                head[i] <= '0;
                tail[i] <= '0;
            end
            cnt         <= '0;
            free_head   <= '0;
            free_tail   <= PW'(DEPTH - 1);
            free_count  <= CW'(DEPTH);
            full        <= 1'b0;
            almost_full <= (DEPTH <= AF_SLACK);
            q           <= '0;
            q_valid     <= 1'b0;
        end else begin
            q_valid <= pop_ok;
            if (pop_ok) q <= mem[h];

            free_count  <= free_n;
            full        <= (free_n == '0);
            almost_full <= (free_n <= CW'(AF_SLACK));

            for (int i = 0; i < FIFOS; i++) begin
                if (flush_ok && flush_fifo == QW'(i))
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + CW'(push_ok && push_fifo == QW'(i))
                                     - CW'(pop_ok && pop_fifo == QW'(i));
            end

            if (flush_ok) begin
                if (free_count == '0) free_head <= head[flush_fifo];
                else                  link[free_tail] <= head[flush_fifo];
                free_tail <= tail[flush_fifo];
            end else begin
                if (pop_ok) head[pop_fifo] <= link[h];
                if (push_ok) begin
                    // Later assignment overrides the pop's head update.
                    if (cnt[push_fifo] == '0 || same_one) head[push_fifo] <= e;
                    else                                  link[tail[push_fifo]] <= e;
                    tail[push_fifo] <= e;
                    free_head       <= link[e];
                end
                if (pop_ok) begin
                    // Free list drained by this cycle's push: freed entry restarts it.
                    if (free_count == CW'(push_ok)) free_head <= h;
                    else                            link[free_tail] <= h;
                    free_tail <= h;
                end
            end
        end
    end

`ifdef LINKED_LIST_FIFO_MQ_ERROR_CHECK_EN
    localparam int SW = CW + QW;
    logic          viol;
    logic [SW-1:0] sum;
    logic [PW-1:0] p;

    // Accounting must cover every entry and each list must reach its tail
    // after exactly count-1 links.
    always_comb begin
        viol = 1'b0;
        sum  = SW'(free_count);
        p    = '0;
        for (int i = 0; i < FIFOS; i++) begin
            sum = sum + SW'(cnt[i]);
            p   = head[i];
            for (int k = 1; k < DEPTH; k++) begin
                if (CW'(k) < cnt[i]) p = link[p];
            end
            if (cnt[i] != '0 && p != tail[i]) viol = 1'b1;
        end
        if (sum != SW'(DEPTH)) viol = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) error <= 1'b0;
        else if ((push && full) || (pop && empty[pop_fifo]) || viol) error <= 1'b1;
    end
`endif

endmodule
